// File: rtl/debug_loader_if.sv
// Byte-stream loader bus: UART-side receive strobe and pipeline status in,
// instruction memory write port and run-control status out.
`timescale 1ns/1ps
interface debug_loader_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    logic [BYTE_W-1:0] i_rx_data;
    logic              i_rx_valid;
    logic              i_program_end;
    logic              o_write_instruction_mem;
    logic [WORD_W-1:0] o_instruction_mem_addr;
    logic [WORD_W-1:0] o_instruction_mem_data;
    logic              o_halt;
    logic              o_loaded;
    logic              o_error;

    modport master (
        output i_rx_data, i_rx_valid, i_program_end,
        input  o_write_instruction_mem, o_instruction_mem_addr, o_instruction_mem_data,
        input  o_halt, o_loaded, o_error
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_program_end,
        output o_write_instruction_mem, o_instruction_mem_addr, o_instruction_mem_data,
        output o_halt, o_loaded, o_error
    );
endinterface

// File: rtl/debug_loader.sv
// Debug loader: assembles received bytes into little-endian instruction words,
// writes them to instruction memory, and gates the pipeline (run / single-step).
`timescale 1ns/1ps
module debug_loader #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic         i_clk,
    input  logic         i_reset,
    debug_loader_if.slave bus
);
    localparam int unsigned AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned WORD_W = 32;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_HALT = 8'h48;

    localparam logic [AW-1:0] LAST_IDX = AW'(MEM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [23:0]         shift_q, shift_d;
    logic [AW-1:0]       widx_q, widx_d;
    logic                wr_q, wr_d;
    logic [WORD_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                loaded_q, loaded_d;
    logic                error_q, error_d;
    logic                halt_q, halt_d;
    logic [WORD_W-1:0]   word_c;

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            shift_q  <= 24'd0;
            widx_q   <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            loaded_q <= 1'b0;
            error_q  <= 1'b0;
            halt_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            widx_q   <= widx_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            loaded_q <= loaded_d;
            error_q  <= error_d;
            halt_q   <= halt_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        widx_d   = widx_q;
        wr_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        loaded_d = loaded_q;
        error_d  = error_q;
        word_c   = {bus.i_rx_data, shift_q};

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == CMD_LOAD) begin
                        state_d  = ST_LOAD;
                        loaded_d = 1'b0;
                        error_d  = 1'b0;
                        widx_d   = '0;
                        cnt_d    = 2'd0;
                    end else if (loaded_q && bus.i_rx_data == CMD_RUN) begin
                        state_d = ST_RUN;
                    end else if (loaded_q && bus.i_rx_data == CMD_STEP) begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.i_rx_valid) begin
                    if (cnt_q == 2'd3) begin
                        // Fourth byte completes the word; the write strobe follows next cycle
                        cnt_d  = 2'd0;
                        wr_d   = 1'b1;
                        addr_d = WORD_W'(widx_q) << 2;
                        data_d = word_c;
                        if (word_c == HALT_WORD) begin
                            loaded_d = 1'b1;
                            state_d  = ST_IDLE;
                        end else if (widx_q == LAST_IDX) begin
                            error_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            widx_d = widx_q + AW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                        unique case (cnt_q)
                            2'd0:    shift_d[7:0]   = bus.i_rx_data;
                            2'd1:    shift_d[15:8]  = bus.i_rx_data;
                            default: shift_d[23:16] = bus.i_rx_data;
                        endcase
                    end
                end
            end
            ST_RUN: begin
                if (bus.i_program_end || (bus.i_rx_valid && bus.i_rx_data == CMD_HALT)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        halt_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    assign bus.o_write_instruction_mem = wr_q;
    assign bus.o_instruction_mem_addr  = addr_q;
    assign bus.o_instruction_mem_data  = data_q;
    assign bus.o_halt                  = halt_q;
    assign bus.o_loaded                = loaded_q;
    assign bus.o_error                 = error_q;

endmodule

// File: tb/tb_debug_loader.sv
// Scoreboard bench for debug_loader (MEM_WORDS=4): expected memory writes are
// queued by the stimulus and popped by a monitor whenever the write strobe is seen.
`timescale 1ns/1ps
module tb_debug_loader;
    logic clk = 1'b0;
    logic rst_n;

    debug_loader_if bus ();

    debug_loader #(.MEM_WORDS(4), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int halt_low = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Monitor: every strobed write must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.o_halt === 1'b0) halt_low++;
        if (bus.o_write_instruction_mem === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         bus.o_instruction_mem_addr, bus.o_instruction_mem_data);
            end else begin
                check("write_addr", bus.o_instruction_mem_addr, exp_addr_q.pop_front());
                check("write_data", bus.o_instruction_mem_data, exp_data_q.pop_front());
            end
        end
    end

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
    endtask

    task automatic gap();
        @(negedge clk);
        bus.i_rx_valid    = 1'b0;
        bus.i_program_end = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_end();
        @(negedge clk);
        bus.i_program_end = 1'b1;
        @(negedge clk);
        bus.i_program_end = 1'b0;
    endtask

    initial begin
        int base;

        // Reset with competing rx strobe ('L') and program_end held active
        rst_n             = 1'b0;
        bus.i_rx_valid    = 1'b1;
        bus.i_rx_data     = 8'h4C;
        bus.i_program_end = 1'b1;
        settle(3);
        check("rst_halt",   32'(bus.o_halt), 32'd1);
        check("rst_wr",     32'(bus.o_write_instruction_mem), 32'd0);
        check("rst_addr",   bus.o_instruction_mem_addr, 32'd0);
        check("rst_data",   bus.o_instruction_mem_data, 32'd0);
        check("rst_loaded", 32'(bus.o_loaded), 32'd0);
        check("rst_error",  32'(bus.o_error), 32'd0);
        bus.i_rx_valid    = 1'b0;
        bus.i_program_end = 1'b0;
        rst_n             = 1'b1;
        settle(2);

        // 'R' / 'S' with nothing loaded are ignored
        base = halt_low;
        put(8'h52); gap(); put(8'h53); gap();
        settle(3);
        check("unloaded_rs_halt", 32'(bus.o_halt), 32'd1);
        check("unloaded_rs_lowcnt", 32'(halt_low - base), 32'd0);

        // Basic load, back-to-back bytes
        expect_write(32'd0, 32'h1234_5678);
        expect_write(32'd4, 32'hFFFF_FFFF);
        base = halt_low;
        put(8'h4C);
        put(8'h78); put(8'h56); put(8'h34); put(8'h12);
        put(8'hFF); put(8'hFF); put(8'hFF); put(8'hFF);
        gap();
        settle(3);
        check("load_loaded", 32'(bus.o_loaded), 32'd1);
        check("load_error",  32'(bus.o_error), 32'd0);
        check("load_halt_lowcnt", 32'(halt_low - base), 32'd0);
        check("hold_addr", bus.o_instruction_mem_addr, 32'd4);
        check("hold_data", bus.o_instruction_mem_data, 32'hFFFF_FFFF);

        // Run, stopped by program_end
        base = halt_low;
        put(8'h52); gap(); #1;
        check("run_halt_low", 32'(bus.o_halt), 32'd0);
        pulse_end();
        settle(2);
        check("run_end_halt", 32'(bus.o_halt), 32'd1);
        check("run_end_lowcnt", 32'(halt_low - base), 32'd2);

        // Run, other byte ignored, then stopped by program_end
        base = halt_low;
        put(8'h52); put(8'h41); gap();
        settle(2);
        check("run_ignore_halt", 32'(bus.o_halt), 32'd0);
        pulse_end();
        settle(2);
        check("run_ignore_lowcnt", 32'(halt_low - base), 32'd5);

        // Run, stopped by 'H'
        base = halt_low;
        put(8'h52); put(8'h48); gap();
        settle(3);
        check("run_h_halt", 32'(bus.o_halt), 32'd1);
        check("run_h_lowcnt", 32'(halt_low - base), 32'd1);

        // Run, 'H' and program_end together act as one stop
        base = halt_low;
        put(8'h52);
        @(negedge clk);
        bus.i_rx_valid = 1'b1; bus.i_rx_data = 8'h48; bus.i_program_end = 1'b1;
        gap();
        settle(3);
        check("run_both_halt", 32'(bus.o_halt), 32'd1);
        check("run_both_lowcnt", 32'(halt_low - base), 32'd1);

        // Three single steps
        base = halt_low;
        put(8'h53); gap(); put(8'h53); gap(); put(8'h53); gap();
        settle(3);
        check("step3_lowcnt", 32'(halt_low - base), 32'd3);

        // Byte during STEP ignored
        base = halt_low;
        put(8'h53); put(8'h52); gap();
        settle(4);
        check("step_ignore_halt", 32'(bus.o_halt), 32'd1);
        check("step_ignore_lowcnt", 32'(halt_low - base), 32'd1);

        // program_end in IDLE ignored
        base = halt_low;
        pulse_end();
        settle(2);
        check("idle_end_halt", 32'(bus.o_halt), 32'd1);
        check("idle_end_loaded", 32'(bus.o_loaded), 32'd1);
        check("idle_end_lowcnt", 32'(halt_low - base), 32'd0);

        // Overflow: 4 words without terminator
        expect_write(32'd0,  32'h0302_0100);
        expect_write(32'd4,  32'h0706_0504);
        expect_write(32'd8,  32'h0B0A_0908);
        expect_write(32'd12, 32'h0F0E_0D0C);
        put(8'h4C);
        for (int i = 0; i < 16; i++) put(8'(i));
        for (int i = 0; i < 8; i++) put(8'(8'h20 + i));
        gap();
        settle(3);
        check("ovf_error",  32'(bus.o_error), 32'd1);
        check("ovf_loaded", 32'(bus.o_loaded), 32'd0);
        check("ovf_hold_addr", bus.o_instruction_mem_addr, 32'd12);
        base = halt_low;
        put(8'h52); gap();
        settle(3);
        check("ovf_run_ignored", 32'(halt_low - base), 32'd0);
        put(8'h4C); gap();
        settle(2);
        check("reload_clears_error", 32'(bus.o_error), 32'd0);

        // Reset mid-word discards the partial bytes
        put(8'hAA); put(8'hBB);
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_write(32'd0, 32'h4433_2211);
        expect_write(32'd4, 32'hFFFF_FFFF);
        put(8'h4C);
        put(8'h11); put(8'h22); put(8'h33); put(8'h44);
        put(8'hFF); put(8'hFF); put(8'hFF); put(8'hFF);
        gap();
        settle(3);
        check("mid_rst_loaded", 32'(bus.o_loaded), 32'd1);

        // Reset coincident with the fourth byte suppresses the strobe
        put(8'h4C); put(8'h01); put(8'h02); put(8'h03);
        @(negedge clk);
        bus.i_rx_valid = 1'b1; bus.i_rx_data = 8'h04; rst_n = 1'b0;
        @(negedge clk);
        bus.i_rx_valid = 1'b0; rst_n = 1'b1;
        settle(3);
        check("supp_loaded", 32'(bus.o_loaded), 32'd0);
        check("supp_addr", bus.o_instruction_mem_addr, 32'd0);
        check("supp_halt", 32'(bus.o_halt), 32'd1);

        settle(2);
        check("writes_outstanding", 32'(exp_addr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
